// File: rtl/lut2_stream.sv
// lut2_stream: runtime-programmable two-input truth table applied bitwise
// across WIDTH-bit operands, behind a valid/ready handshake with a
// one-stage output register. FOLD mode reduces a packet to one result.
//
// state | meaning
// IDLE  | no packet in progress; next accepted beat starts from f(i_a,i_b)
// ACC   | FOLD packet in progress; acc holds the running reduction
module lut2_stream #(
  parameter int         WIDTH    = 1,
  parameter logic [3:0] TT_RESET = 4'b1011
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_we,
  input  logic [3:0]       i_cfg_tt,
  input  logic             i_cfg_mode,
  output logic             o_cfg_busy,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_c,
  output logic [7:0]       o_count
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  localparam logic MODE_MAP  = 1'b0;
  localparam logic MODE_FOLD = 1'b1;

  state_t           state_q, state_d;
  logic [3:0]       tt_q;
  logic             mode_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] c_d;
  logic [7:0]       count_d;
  logic             valid_d;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] f_map;
  logic [WIDTH-1:0] f_fold;
  logic [7:0]       cnt_next;

  function automatic logic [WIDTH-1:0] lut_apply(input logic [3:0]       tt,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < WIDTH; k++) begin
      r[k] = tt[{x[k], y[k]}];
    end
    return r;
  endfunction

  assign o_ready    = ~o_valid | i_ready;
  assign o_cfg_busy = (state_q == ACC) | o_valid;
  assign accept     = i_valid & o_ready;

  // In ACC the running accumulator replaces i_a as the x operand.
  assign f_map    = lut_apply(tt_q, i_a, i_b);
  assign f_fold   = lut_apply(tt_q, (state_q == ACC) ? acc_q : i_a, i_b);
  assign cnt_next = (state_q == IDLE) ? 8'd1 :
                    (cnt_q == 8'd255) ? 8'd255 : cnt_q + 8'd1;

  // Next-state, accumulator and output-register load decisions.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    c_d     = o_c;
    count_d = o_count;
    if (accept) begin
      if (mode_q == MODE_MAP) begin
        load    = 1'b1;
        c_d     = f_map;
        count_d = 8'd1;
      end else begin
        acc_d = f_fold;
        cnt_d = cnt_next;
        if (i_last) begin
          load    = 1'b1;
          c_d     = f_fold;
          count_d = cnt_next;
          state_d = IDLE;
        end else begin
          state_d = ACC;
        end
      end
    end
    // A fresh result wins over consumption of the current one.
    if (load)         valid_d = 1'b1;
    else if (i_ready) valid_d = 1'b0;
    else              valid_d = o_valid;
  end

  // FSM, accumulator and output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= 8'd0;
      o_valid <= 1'b0;
      o_c     <= '0;
      o_count <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_valid <= valid_d;
      o_c     <= c_d;
      o_count <= count_d;
    end
  end

  // Configuration register; writes while busy are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tt_q   <= TT_RESET;
      mode_q <= MODE_MAP;
    end else if (i_cfg_we && !o_cfg_busy) begin
      tt_q   <= i_cfg_tt;
      mode_q <= i_cfg_mode;
    end
  end

endmodule

// File: doc/lut2_stream.md
Name: lut2_stream

Overview:
- Parametrised, registered successor to the single-bit two-input gate.
- Applies a runtime-programmable two-input truth table bitwise across WIDTH-bit operand vectors.
- Sits behind a valid/ready handshake with a one-stage output register.
- Adds a FOLD mode that reduces a multi-beat packet (terminated by i_last) to a single result plus a beat count.

Parameters:
- WIDTH, 1, bit width of i_a, i_b and o_c.
- TT_RESET, 4'b1011, truth table loaded at reset. Bit index is {x,y}, so the default gives f=1 for 00/01/11 and f=0 for 10.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_cfg_we  in  1  configuration write strobe.
- i_cfg_tt  in  4  new truth table.
- i_cfg_mode  in  1  new mode: 0=MAP, 1=FOLD.
- o_cfg_busy  out  1  high while a configuration write would be ignored.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted when i_valid & o_ready.
- i_a  in  WIDTH  operand x.
- i_b  in  WIDTH  operand y.
- i_last  in  1  final beat of a FOLD packet; ignored in MAP.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result when o_valid & i_ready.
- o_c  out  WIDTH  result vector.
- o_count  out  8  number of beats folded into o_c; saturates at 255.

Behaviour:
- Bitwise function: f(x,y)[k] = tt[{x[k],y[k]}] for each bit k.
- Reset (asynchronous, active-low):
  - Outputs: o_valid=0, o_c=0, o_count=0.
  - State: tt=TT_RESET, mode=MAP, FSM=IDLE, acc=0.
  - Reset asserted mid-packet discards the partial accumulation; nothing is emitted.
- Input handshake:
  - o_ready = ~o_valid | i_ready, purely combinational; this gives full throughput with no bubbles.
  - The output register loads only when o_ready is high.
- Output handshake:
  - o_valid, o_c and o_count hold stable while o_valid & ~i_ready.
  - o_valid drops on the cycle after the result is taken, unless a new result loads in the same cycle.
- MAP mode:
  - Each accepted beat registers o_c=f(i_a,i_b) and o_count=1, with o_valid=1 on the next edge.
  - Latency is 1 cycle.
- FOLD mode FSM, states IDLE and ACC:
  - IDLE, accepted beat: acc=f(i_a,i_b), cnt=1.
    - If i_last: o_c=acc, o_count=1, o_valid=1; stay IDLE.
    - Else go to ACC.
  - ACC, accepted beat: acc=f(acc,i_b), with i_a ignored; cnt=min(cnt+1,255).
    - If i_last: register o_c=f(acc,i_b) and o_count=new cnt, set o_valid=1, go to IDLE.
  - Non-last beats produce no output but obey the same o_ready rule.
  - Result latency is 1 cycle after the last beat.
- Configuration:
  - o_cfg_busy = (FSM==ACC) | o_valid.
  - i_cfg_we with o_cfg_busy=0 loads tt and mode on that edge.
  - i_cfg_we with o_cfg_busy=1 is dropped silently; there is no queuing.
  - A beat accepted in the same cycle as a successful write uses the old tt/mode; the new values apply from the next cycle.
- Width: all operations are bitwise with no carries. o_count is 8 bits and never wraps.

Test Plan:
- Default table, WIDTH=1, MAP, i_ready=1: (a,b)=(0,0),(0,1),(1,0),(1,1), one per cycle -> o_c=1,1,0,1, each one cycle after acceptance; o_count=1.
- Backpressure, MAP, WIDTH=4, tt=4'b0110 (XOR): beats (1100,1010) then (1111,0001) with i_ready=0 for 3 cycles.
  - Required: o_c=0110 held and o_ready=0 throughout.
  - After i_ready=1: o_c=1110 next; no beat lost or duplicated.
- FOLD, WIDTH=4, tt=4'b1000 (AND): beats (a=1111,b=1010), (b=0110), (b=1111,last) -> single result o_c=0010, o_count=3; no o_valid on the first two beats.
- Config while busy: mid-FOLD packet, write tt=4'b0001 -> o_cfg_busy=1, write ignored, packet uses the old table. The same write after o_valid is consumed takes effect: MAP (0,0) -> 1.
- Reset mid-packet: two FOLD beats, then i_rst_n=0 for 1 cycle.
  - Required: o_valid=0 immediately (asynchronous), tt=1011, mode=MAP.
  - Next beat (1,0) -> o_c=0.
- Saturation: FOLD packet of 300 beats with tt=4'b1010 (f=y) -> o_count=255, o_c equals the last beat's i_b.
